uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Round-robin frame scheduler that shares one UART transmitter between N_REQ byte-stream requesters.
- Grants the transmitter for a whole frame, which ends at the byte marked last, so frames never interleave.
- Feeds bytes one at a time over the UART's valid/ready handshake, with a configurable inter-byte gap and an acknowledge timeout.
- Sits between the command/science packet builders and the RS422 UART transmit path.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- GAP_CYCLES, 16, idle clk cycles inserted after each byte completes (0 allowed).
- ACK_TO, 1023, maximum clk cycles to wait for the UART to drop ready after a tx_valid pulse.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  N_REQ  per-requester byte available.
- s_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- s_last  in  N_REQ  marks the final byte of a frame.
- s_parity  in  N_REQ  per-requester parity select.
- s_stopbit  in  2*N_REQ  per-requester stop-bit field.
- s_ready  out  N_REQ  byte accepted when s_valid&s_ready.
- tx_valid  out  1  one-cycle pulse requesting a UART send.
- tx_data  out  8  byte to send; held until the next load.
- tx_parity  out  1  parity config for the UART, latched per frame.
- tx_stopbit  out  2  stop-bit config for the UART, latched per frame.
- tx_ready  in  1  UART idle/done level (1 = idle).
- grant  out  N_REQ  one-hot owner of the current frame; 0 when idle.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  one-cycle pulse when the acknowledge timeout fires.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; s_ready=0; tx_valid=0; tx_data=0x00; tx_parity=0; tx_stopbit=2'b11; grant=0; busy=0; err_timeout=0; rr_ptr=N_REQ-1; counters=0.
- IDLE:
  - If any s_valid is high, pick the first requester at or after rr_ptr+1 (modulo N_REQ) with s_valid high.
  - Register grant (one-hot), tx_parity and tx_stopbit from the winner, set rr_ptr to the winner, go to LOAD.
  - Arbitration happens only in IDLE; mid-frame s_valid on other requesters is ignored.
- LOAD:
  - s_ready = grant (combinational, this state only).
  - On s_valid[g]&s_ready[g]: capture tx_data and a last flag.
  - If tx_ready=1, go to SEND; otherwise go to WAIT_IDLE.
  - If s_valid[g]=0, hold in LOAD with no timeout; the requester owns the frame.
- WAIT_IDLE: hold until tx_ready=1, then go to SEND.
- SEND: tx_valid=1 for exactly one cycle, clear the timeout counter, go to WAIT_ACK.
- WAIT_ACK:
  - When tx_ready=0, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches ACK_TO: pulse err_timeout, clear the counter, and go to FLUSH if last=0 or to IDLE if last=1.
- WAIT_DONE:
  - When tx_ready=1: if GAP_CYCLES>0, go to GAP and load the gap counter.
  - Otherwise go to LOAD if last=0, or to IDLE if last=1 (clearing grant).
- GAP: count GAP_CYCLES cycles, then follow the same last-based exit as WAIT_DONE.
- FLUSH:
  - s_ready=grant; accept and discard bytes until a byte with s_last=1 is accepted, then go to IDLE.
  - tx_valid is never asserted in FLUSH.
- Latency: requester valid in IDLE → grant at +1 → byte captured at +1 (LOAD) → tx_valid at +2, provided tx_ready=1 throughout.
- tx_parity and tx_stopbit are stable for the whole frame, including while the UART shifts out the last byte.
- Counter widths: $clog2(ACK_TO+1) and $clog2(GAP_CYCLES+1) bits; counters never wrap.
- Simultaneous events:
  - s_valid rising on several requesters in the same IDLE cycle: round-robin order decides.
  - tx_ready dropping in the same cycle as the timeout compare: ACK wins, no error.
- Reset mid-frame: abandon immediately. s_ready and tx_valid drop in the cycle after rst is sampled. The partial frame is not flushed; the requester must restart its frame.
- Single-byte frame (s_last=1 on the first byte): the sequence is LOAD→SEND→WAIT_ACK→WAIT_DONE→(GAP)→IDLE.

Test Plan:
- Req0 sends 3 bytes 0xA5,0x5A,0xFF (last on 0xFF); model UART drops ready 1 cycle after tx_valid and stays low 120 cycles → exactly 3 tx_valid pulses in order, gaps ≥ GAP_CYCLES between done and the next pulse, grant=01 throughout, busy falls after the final gap.
- Req0 and req1 both valid in the same IDLE cycle, from reset → req0 frame first, then req1. Repeat → req1 first, req0 second; frames never interleave.
- Req0 frame in progress while req1 asserts valid mid-frame → req1 s_ready stays 0 until req0's last byte completes; then grant=10.
- UART model never drops ready after the pulse, in a 4-byte frame → err_timeout pulses ACK_TO cycles after tx_valid; the remaining 3 bytes are accepted via s_ready with no tx_valid; state returns to IDLE.
- tx_ready=0 when a byte is loaded (UART still finishing) → tx_valid waits until tx_ready=1, then pulses once; tx_data is unchanged between capture and pulse.
- Assert rst during WAIT_DONE of byte 2 → next cycle s_ready=0, tx_valid=0, grant=0, busy=0. A new req1 frame then starts normally with rr_ptr at reset value (req0 favoured).

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Signal bundle between the byte-stream requesters, the frame scheduler and the
// UART transmit path. "master" is the scheduler side; "slave" is its environment.
interface uart_tx_sched_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   s_valid;
  logic [8*N_REQ-1:0] s_data;
  logic [N_REQ-1:0]   s_last;
  logic [N_REQ-1:0]   s_parity;
  logic [2*N_REQ-1:0] s_stopbit;
  logic [N_REQ-1:0]   s_ready;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               tx_parity;
  logic [1:0]         tx_stopbit;
  logic               tx_ready;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               err_timeout;

  modport master (
    input  s_valid, s_data, s_last, s_parity, s_stopbit, tx_ready,
    output s_ready, tx_valid, tx_data, tx_parity, tx_stopbit, grant, busy, err_timeout
  );

  modport slave (
    output s_valid, s_data, s_last, s_parity, s_stopbit, tx_ready,
    input  s_ready, tx_valid, tx_data, tx_parity, tx_stopbit, grant, busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin frame scheduler sharing one UART transmitter between N_REQ requesters;
// a grant lasts a whole frame, bytes are paced by an inter-byte gap and an ack timeout.
module uart_tx_sched #(
  parameter int N_REQ      = 2,
  parameter int GAP_CYCLES = 16,
  parameter int ACK_TO     = 1023
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_sched_if.master bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW = $clog2(ACK_TO + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_IDLE, SEND, WAIT_ACK, WAIT_DONE, GAP, FLUSH
  } state_t;

  state_t           state, state_nx;
  logic [N_REQ-1:0] grant_q;
  logic [PW-1:0]    g_idx, rr_ptr, arb_idx;
  logic             arb_found;
  logic             last_q;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [1:0]       stopbit_q;
  logic [AW-1:0]    ack_cnt;
  logic [GW-1:0]    gap_cnt;

  logic g_valid, g_last, ack_hit, gap_done;

  assign g_valid  = |(bus.s_valid & grant_q);
  assign g_last   = |(bus.s_last & grant_q);
  assign ack_hit  = (ack_cnt == AW'(ACK_TO - 1));
  assign gap_done = (gap_cnt == GW'(1));

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    logic [PW-1:0] cand;
    arb_found = 1'b0;
    arb_idx   = rr_ptr;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!arb_found && bus.s_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: state_nx is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (arb_found) state_nx = LOAD;
      LOAD:      if (g_valid) state_nx = bus.tx_ready ? SEND : WAIT_IDLE;
      WAIT_IDLE: if (bus.tx_ready) state_nx = SEND;
      SEND:      state_nx = WAIT_ACK;
      WAIT_ACK: begin
        // A falling tx_ready in the compare cycle counts as an ack, not a timeout.
        if (!bus.tx_ready)  state_nx = WAIT_DONE;
        else if (ack_hit)   state_nx = last_q ? IDLE : FLUSH;
      end
      WAIT_DONE: begin
        if (bus.tx_ready) begin
          if (GAP_CYCLES > 0) state_nx = GAP;
          else                state_nx = last_q ? IDLE : LOAD;
        end
      end
      GAP:       if (gap_done) state_nx = last_q ? IDLE : LOAD;
      FLUSH:     if (g_valid && g_last) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // NOTE: every datapath register has a defined reset value; there is no memory
  // array here, so nothing is left uninitialised.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q   <= '0;
      g_idx     <= '0;
      rr_ptr    <= PW'(N_REQ - 1);
      data_q    <= 8'h00;
      last_q    <= 1'b0;
      parity_q  <= 1'b0;
      stopbit_q <= 2'b11;
      ack_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      if (state == IDLE && arb_found) begin
        grant_q   <= N_REQ'(1) << arb_idx;
        g_idx     <= arb_idx;
        rr_ptr    <= arb_idx;
        parity_q  <= bus.s_parity[arb_idx];
        stopbit_q <= bus.s_stopbit[{arb_idx, 1'b0} +: 2];
      end
      if (state != IDLE && state_nx == IDLE) grant_q <= '0;
      if (state == LOAD && g_valid) begin
        data_q <= bus.s_data[{g_idx, 3'b000} +: 8];
        last_q <= g_last;
      end
      case (state)
        SEND:      ack_cnt <= '0;
        WAIT_ACK:  if (bus.tx_ready) ack_cnt <= ack_hit ? '0 : ack_cnt + 1'b1;
        WAIT_DONE: if (bus.tx_ready) gap_cnt <= GW'(GAP_CYCLES);
        GAP:       gap_cnt <= gap_cnt - 1'b1;
        default:   ;
      endcase
    end
  end

  always_comb begin
    bus.s_ready     = '0;
    bus.tx_valid    = 1'b0;
    bus.err_timeout = 1'b0;
    case (state)
      LOAD, FLUSH: bus.s_ready = grant_q;
      SEND:        bus.tx_valid = 1'b1;
      WAIT_ACK:    bus.err_timeout = bus.tx_ready && ack_hit;
      default:     ;
    endcase
  end

  assign bus.busy       = (state != IDLE);
  assign bus.grant      = grant_q;
  assign bus.tx_data    = data_q;
  assign bus.tx_parity  = parity_q;
  assign bus.tx_stopbit = stopbit_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: queued requester frames, a behavioural UART
// that goes busy after each tx_valid, and per-scenario inline checks.
module tb_uart_tx_sched;
  localparam int N_REQ     = 2;
  localparam int GAP       = 16;
  localparam int ACK_TO    = 1023;
  localparam int UART_BUSY = 120;
  // Pulse-to-pulse spacing: 120 busy + 1 done + 16 gap + LOAD + SEND = 139.
  localparam int PERIOD    = 139;
  // Last pulse to IDLE: 120 busy + 1 done + 16 gap + 1 = 138.
  localparam int TO_IDLE   = 138;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_sched #(.N_REQ(N_REQ), .GAP_CYCLES(GAP), .ACK_TO(ACK_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // UART model: ready drops the cycle after a tx_valid and stays low UART_BUSY cycles.
  int busy_cnt  = 0;
  bit uart_ack  = 1'b1;
  bit hold_busy = 1'b0;
  always @(posedge clk) begin
    if (bus.tx_valid && uart_ack) busy_cnt <= UART_BUSY;
    else if (busy_cnt > 0)        busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_ready = (busy_cnt == 0) && !hold_busy;

  logic [8:0]       q0[$];
  logic [8:0]       q1[$];
  int               pulse_cyc[$];
  logic [7:0]       pulse_dat[$];
  logic [N_REQ-1:0] pulse_gnt[$];
  int               err_cyc[$];
  int               acc_cnt0;
  int               sready_viol;
  int               cyc;
  int               n_checks;
  int               n_pass;

  task automatic drive();
    bus.s_valid = '0;
    bus.s_data  = {8'hEE, 8'hEE};
    bus.s_last  = '0;
    if (q0.size() > 0) begin
      bus.s_valid[0]  = 1'b1;
      bus.s_data[7:0] = q0[0][7:0];
      bus.s_last[0]   = q0[0][8];
    end
    if (q1.size() > 0) begin
      bus.s_valid[1]   = 1'b1;
      bus.s_data[15:8] = q1[0][7:0];
      bus.s_last[1]    = q1[0][8];
    end
  endtask

  // One clock: note handshakes, advance, then drive and log 1 time unit after the edge.
  task automatic step();
    logic [N_REQ-1:0] acc;
    acc = bus.s_valid & bus.s_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc[0]) begin q0.delete(0); acc_cnt0++; end
    if (acc[1]) q1.delete(0);
    drive();
    if (bus.tx_valid) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(bus.tx_data);
      pulse_gnt.push_back(bus.grant);
    end
    if (bus.err_timeout) err_cyc.push_back(cyc);
    if ((bus.s_ready & ~bus.grant) != '0) sready_viol++;
  endtask

  task automatic clear_logs();
    pulse_cyc.delete();
    pulse_dat.delete();
    pulse_gnt.delete();
    err_cyc.delete();
    sready_viol = 0;
  endtask

  task automatic wait_all_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((bus.busy || q0.size() > 0 || q1.size() > 0) && n < max_cyc) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= max_cyc) $display("FAIL %s_idle: still busy after %0d cycles, want idle", name, n);
    else n_pass++;
  endtask

  task automatic wait_pulses(input string name, input int cnt, input int max_cyc);
    int n;
    n = 0;
    while (pulse_dat.size() < cnt && n < max_cyc) begin
      step();
      n++;
    end
    n_checks++;
    if (pulse_dat.size() < cnt) $display("FAIL %s_pulses: got %0d pulses, want %0d", name, pulse_dat.size(), cnt);
    else n_pass++;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.s_ready !== 2'b00 || bus.tx_valid !== 1'b0 || bus.err_timeout !== 1'b0)
      $display("FAIL reset_strobes: got s_ready=%b tx_valid=%b err=%b, want 00 0 0",
               bus.s_ready, bus.tx_valid, bus.err_timeout);
    else n_pass++;
    n_checks++;
    if (bus.grant !== 2'b00 || bus.busy !== 1'b0)
      $display("FAIL reset_grant: got grant=%b busy=%b, want 00 0", bus.grant, bus.busy);
    else n_pass++;
    n_checks++;
    if ({bus.tx_data, bus.tx_parity, bus.tx_stopbit} !== {8'h00, 1'b0, 2'b11})
      $display("FAIL reset_config: got data=%h par=%b stop=%b, want 00 0 11",
               bus.tx_data, bus.tx_parity, bus.tx_stopbit);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [7:0] exp_d [3];
    int c0, n, gviol;
    exp_d = '{8'hA5, 8'h5A, 8'hFF};
    clear_logs();
    q0.push_back({1'b0, 8'hA5});
    q0.push_back({1'b0, 8'h5A});
    q0.push_back({1'b1, 8'hFF});
    drive();
    c0 = cyc;
    step();
    n_checks++;
    if (bus.grant !== 2'b01 || bus.busy !== 1'b1)
      $display("FAIL frame_grant: got grant=%b busy=%b, want 01 1", bus.grant, bus.busy);
    else n_pass++;
    n_checks++;
    if ({bus.tx_parity, bus.tx_stopbit} !== 3'b001)
      $display("FAIL frame_cfg: got par=%b stop=%b, want 0 01", bus.tx_parity, bus.tx_stopbit);
    else n_pass++;
    n = 0;
    gviol = 0;
    while (bus.busy && n < 3000) begin
      if (bus.grant !== 2'b01) gviol++;
      step();
      n++;
    end
    n_checks++;
    if (gviol != 0 || n >= 3000) $display("FAIL frame_hold: got %0d bad-grant cycles (n=%0d), want 0", gviol, n);
    else n_pass++;
    n_checks++;
    if (pulse_dat.size() != 3) $display("FAIL frame_count: got %0d pulses, want 3", pulse_dat.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= pulse_dat.size() || pulse_dat[i] !== exp_d[i])
        $display("FAIL frame_byte%0d: got %h, want %h", i, (i < pulse_dat.size()) ? pulse_dat[i] : 8'hxx, exp_d[i]);
      else n_pass++;
    end
    if (pulse_cyc.size() == 3) begin
      n_checks++;
      if (pulse_cyc[0] != c0 + 2) $display("FAIL frame_latency: got %0d, want %0d", pulse_cyc[0] - c0, 2);
      else n_pass++;
      n_checks++;
      if (pulse_cyc[1] - pulse_cyc[0] != PERIOD || pulse_cyc[2] - pulse_cyc[1] != PERIOD)
        $display("FAIL frame_gap: got %0d,%0d, want %0d", pulse_cyc[1] - pulse_cyc[0],
                 pulse_cyc[2] - pulse_cyc[1], PERIOD);
      else n_pass++;
      n_checks++;
      if (cyc - pulse_cyc[2] != TO_IDLE || bus.grant !== 2'b00)
        $display("FAIL frame_busy_fall: got %0d grant=%b, want %0d 00", cyc - pulse_cyc[2], bus.grant, TO_IDLE);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [7:0]       d1 [4];
    logic [N_REQ-1:0] g1 [4];
    logic [7:0]       d2 [4];
    logic [N_REQ-1:0] g2 [4];
    d1 = '{8'h11, 8'h12, 8'h21, 8'h22};
    g1 = '{2'b01, 2'b01, 2'b10, 2'b10};
    d2 = '{8'h23, 8'h24, 8'h13, 8'h14};
    g2 = '{2'b10, 2'b10, 2'b01, 2'b01};
    reset_dut();
    clear_logs();
    q0.push_back({1'b0, 8'h11}); q0.push_back({1'b1, 8'h12});
    q1.push_back({1'b0, 8'h21}); q1.push_back({1'b1, 8'h22});
    drive();
    wait_all_idle("rr_first", 3000);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= pulse_dat.size() || pulse_dat[i] !== d1[i] || pulse_gnt[i] !== g1[i])
        $display("FAIL rr_first%0d: got %h/%b, want %h/%b", i, (i < pulse_dat.size()) ? pulse_dat[i] : 8'hxx,
                 (i < pulse_gnt.size()) ? pulse_gnt[i] : 2'bxx, d1[i], g1[i]);
      else n_pass++;
    end
    // A lone req0 frame leaves req0 as last winner, so req1 is favoured next.
    q0.push_back({1'b1, 8'h71});
    drive();
    wait_all_idle("rr_solo", 1000);
    clear_logs();
    q0.push_back({1'b0, 8'h13}); q0.push_back({1'b1, 8'h14});
    q1.push_back({1'b0, 8'h23}); q1.push_back({1'b1, 8'h24});
    drive();
    wait_all_idle("rr_second", 3000);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= pulse_dat.size() || pulse_dat[i] !== d2[i] || pulse_gnt[i] !== g2[i])
        $display("FAIL rr_second%0d: got %h/%b, want %h/%b", i, (i < pulse_dat.size()) ? pulse_dat[i] : 8'hxx,
                 (i < pulse_gnt.size()) ? pulse_gnt[i] : 2'bxx, d2[i], g2[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mid_frame();
    logic [7:0] exp_d [5];
    int n;
    exp_d = '{8'h81, 8'h82, 8'h83, 8'h91, 8'h92};
    clear_logs();
    q0.push_back({1'b0, 8'h81}); q0.push_back({1'b0, 8'h82}); q0.push_back({1'b1, 8'h83});
    drive();
    wait_pulses("mid_start", 1, 500);
    q1.push_back({1'b0, 8'h91}); q1.push_back({1'b1, 8'h92});
    drive();
    n = 0;
    while (bus.grant !== 2'b10 && n < 2000) begin
      step();
      n++;
    end
    n_checks++;
    if (bus.grant !== 2'b10 || pulse_dat.size() != 3)
      $display("FAIL mid_handover: got grant=%b after %0d pulses, want 10 after 3", bus.grant, pulse_dat.size());
    else n_pass++;
    n_checks++;
    if ({bus.tx_parity, bus.tx_stopbit} !== 3'b110)
      $display("FAIL mid_cfg: got par=%b stop=%b, want 1 10", bus.tx_parity, bus.tx_stopbit);
    else n_pass++;
    wait_all_idle("mid", 2000);
    n_checks++;
    if (sready_viol != 0) $display("FAIL mid_sready: got %0d non-owner ready cycles, want 0", sready_viol);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= pulse_dat.size() || pulse_dat[i] !== exp_d[i])
        $display("FAIL mid_byte%0d: got %h, want %h", i, (i < pulse_dat.size()) ? pulse_dat[i] : 8'hxx, exp_d[i]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int acc0;
    uart_ack = 1'b0;
    clear_logs();
    acc0 = acc_cnt0;
    q0.push_back({1'b0, 8'h31}); q0.push_back({1'b0, 8'h32});
    q0.push_back({1'b0, 8'h33}); q0.push_back({1'b1, 8'h34});
    drive();
    wait_all_idle("to", 3000);
    uart_ack = 1'b1;
    n_checks++;
    if (pulse_dat.size() != 1 || err_cyc.size() != 1)
      $display("FAIL to_counts: got %0d pulses %0d errs, want 1 1", pulse_dat.size(), err_cyc.size());
    else n_pass++;
    if (pulse_cyc.size() == 1 && err_cyc.size() == 1) begin
      n_checks++;
      if (err_cyc[0] - pulse_cyc[0] != ACK_TO)
        $display("FAIL to_delay: got %0d, want %0d", err_cyc[0] - pulse_cyc[0], ACK_TO);
      else n_pass++;
      n_checks++;
      if (cyc - pulse_cyc[0] != ACK_TO + 4)
        $display("FAIL to_flush_end: got %0d, want %0d", cyc - pulse_cyc[0], ACK_TO + 4);
      else n_pass++;
    end
    n_checks++;
    if (acc_cnt0 - acc0 != 4) $display("FAIL to_accepted: got %0d, want 4", acc_cnt0 - acc0);
    else n_pass++;
  endtask

  task automatic test_wait_idle();
    int rel;
    hold_busy = 1'b1;
    clear_logs();
    q0.push_back({1'b1, 8'h3C});
    drive();
    step();
    step();
    n_checks++;
    if (bus.tx_data !== 8'h3C || bus.tx_valid !== 1'b0)
      $display("FAIL wi_capture: got data=%h valid=%b, want 3c 0", bus.tx_data, bus.tx_valid);
    else n_pass++;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (bus.tx_data !== 8'h3C || pulse_dat.size() != 0)
      $display("FAIL wi_hold: got data=%h pulses=%0d, want 3c 0", bus.tx_data, pulse_dat.size());
    else n_pass++;
    hold_busy = 1'b0;
    rel = cyc;
    wait_all_idle("wi", 1000);
    n_checks++;
    if (pulse_dat.size() != 1 || pulse_dat[0] !== 8'h3C || pulse_cyc[0] != rel + 1)
      $display("FAIL wi_pulse: got %0d pulses first at +%0d, want 1 at +1",
               pulse_dat.size(), (pulse_cyc.size() > 0) ? pulse_cyc[0] - rel : -1);
    else n_pass++;
    n_checks++;
    if (pulse_cyc.size() == 0 || cyc - pulse_cyc[0] != TO_IDLE)
      $display("FAIL wi_single_end: got %0d, want %0d", (pulse_cyc.size() > 0) ? cyc - pulse_cyc[0] : -1, TO_IDLE);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    q0.push_back({1'b0, 8'h41}); q0.push_back({1'b0, 8'h42}); q0.push_back({1'b1, 8'h43});
    drive();
    wait_pulses("rm_start", 2, 1000);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    n_checks++;
    if (bus.s_ready !== 2'b00 || bus.tx_valid !== 1'b0 || bus.grant !== 2'b00 || bus.busy !== 1'b0)
      $display("FAIL rm_abandon: got s_ready=%b valid=%b grant=%b busy=%b, want 00 0 00 0",
               bus.s_ready, bus.tx_valid, bus.grant, bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.tx_data !== 8'h00) $display("FAIL rm_data: got %h, want 00", bus.tx_data);
    else n_pass++;
    rst = 1'b0;
    q0.delete();
    clear_logs();
    q0.push_back({1'b1, 8'h61});
    q1.push_back({1'b1, 8'h51});
    drive();
    step();
    n_checks++;
    if (bus.grant !== 2'b01) $display("FAIL rm_rr_reset: got grant=%b, want 01", bus.grant);
    else n_pass++;
    wait_all_idle("rm", 2000);
    n_checks++;
    if (pulse_dat.size() != 2 || pulse_dat[0] !== 8'h61 || pulse_dat[1] !== 8'h51 || pulse_gnt[1] !== 2'b10)
      $display("FAIL rm_restart: got %0d pulses, want 61 then 51 from req1", pulse_dat.size());
    else n_pass++;
  endtask

  initial begin
    rst           = 1'b1;
    cyc           = 0;
    n_checks      = 0;
    n_pass        = 0;
    acc_cnt0      = 0;
    sready_viol   = 0;
    bus.s_parity  = 2'b10;
    bus.s_stopbit = 4'b10_01;
    drive();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_mid_frame();
    test_timeout();
    test_wait_idle();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
